// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the two-requester RAM port arbiter: RAM command
// opcodes, command word width and the transaction FSM encoding.
package ram_port_arbiter_pkg;

  localparam int CMD_W = 10;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_RCMD  = 3'd3,
    ST_CAPT  = 3'd4
  } state_t;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-input grant logic: round-robin when rr_en is high, otherwise requester 0
// has fixed priority. last_grant_q records the most recent winner.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en_update,
  input  logic       rr_en,
  output logic [1:0] gnt
);

  logic lastGrant_q;
  logic lastGrant_d;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (rr_en && !lastGrant_q) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    lastGrant_d = lastGrant_q;
    if (en_update && (gnt != 2'b00)) begin
      lastGrant_d = gnt[1];
    end
  end

  // Resetting to 1 hands the first contention to requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      lastGrant_q <= 1'b1;
    end else begin
      lastGrant_q <= lastGrant_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a single-port 256x8 RAM between two requesters, turning each accepted
// read or write into the RAM's 10-bit command sequence and a per-requester response.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter bit RR_EN     = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_we,
  input  logic [ADDR_SIZE-1:0] req0_addr,
  input  logic [7:0]           req0_wdata,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_we,
  input  logic [ADDR_SIZE-1:0] req1_addr,
  input  logic [7:0]           req1_wdata,
  output logic                 rsp0_valid,
  output logic [7:0]           rsp0_rdata,
  output logic                 rsp1_valid,
  output logic [7:0]           rsp1_rdata,
  output logic [CMD_W-1:0]     ram_din,
  output logic                 ram_rx_valid,
  input  logic [7:0]           ram_dout,
  input  logic                 ram_tx_valid,
  output logic                 busy,
  output logic                 rd_err
);

  state_t state_q, state_d;

  logic                 we_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [7:0]           wdata_q;
  logic                 owner_q;

  logic       rsp0Valid_q, rsp1Valid_q;
  logic [7:0] rsp0Rdata_q, rsp1Rdata_q;
  logic       rdErr_q;

  logic [1:0] arbReq;
  logic [1:0] gnt;
  logic       accept;
  logic       rspFire;
  logic [7:0] rspData;
  logic [7:0] addrExt;

  // Requests are only offered to the arbiter when a new transaction can start.
  assign arbReq = {req1_valid, req0_valid} & {2{(state_q == ST_IDLE) && !rst}};
  assign accept = gnt[0] | gnt[1];

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (arbReq),
    .en_update (accept),
    .rr_en     (RR_EN),
    .gnt       (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_comb begin
    addrExt                = '0;
    addrExt[ADDR_SIZE-1:0] = addr_q;
  end

  always_comb begin
    state_d      = state_q;
    ram_din      = '0;
    ram_rx_valid = 1'b0;
    rspFire      = 1'b0;
    rspData      = 8'h00;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        ram_rx_valid = 1'b1;
        ram_din      = {(we_q ? OP_WR_ADDR : OP_RD_ADDR), addrExt};
        state_d      = we_q ? ST_WDATA : ST_RCMD;
      end
      ST_WDATA: begin
        ram_rx_valid = 1'b1;
        ram_din      = {OP_WR_DATA, wdata_q};
        rspFire      = 1'b1;
        state_d      = ST_IDLE;
      end
      ST_RCMD: begin
        ram_rx_valid = 1'b1;
        ram_din      = {OP_RD_DATA, 8'h00};
        state_d      = ST_CAPT;
      end
      ST_CAPT: begin
        rspFire = 1'b1;
        rspData = ram_dout;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request fields are sampled only at accept and held for the whole transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      owner_q <= 1'b0;
    end else if (accept) begin
      we_q    <= gnt[1] ? req1_we    : req0_we;
      addr_q  <= gnt[1] ? req1_addr  : req0_addr;
      wdata_q <= gnt[1] ? req1_wdata : req0_wdata;
      owner_q <= gnt[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0Valid_q <= 1'b0;
      rsp1Valid_q <= 1'b0;
      rsp0Rdata_q <= 8'h00;
      rsp1Rdata_q <= 8'h00;
    end else begin
      rsp0Valid_q <= rspFire && !owner_q;
      rsp1Valid_q <= rspFire && owner_q;
      if (rspFire && !owner_q) begin
        rsp0Rdata_q <= rspData;
      end
      if (rspFire && owner_q) begin
        rsp1Rdata_q <= rspData;
      end
    end
  end

  // The RAM's valid flag is sticky, so a low value at capture means no read ever landed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdErr_q <= 1'b0;
    end else if ((state_q == ST_CAPT) && !ram_tx_valid) begin
      rdErr_q <= 1'b1;
    end
  end

  assign rsp0_valid = rsp0Valid_q;
  assign rsp1_valid = rsp1Valid_q;
  assign rsp0_rdata = rsp0Rdata_q;
  assign rsp1_rdata = rsp1Rdata_q;
  assign rd_err     = rdErr_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 256x8 RAM model;
// a second instance with fixed priority shares the same stimulus.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_we, req1_valid, req1_we;
  logic [7:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;
  logic       busy, rd_err;

  logic       fpReq0Ready, fpReq1Ready, fpRsp0Valid, fpRsp1Valid;
  logic [7:0] fpRsp0Rdata, fpRsp1Rdata;
  logic [9:0] fpRamDin;
  logic       fpRamRxValid, fpBusy, fpRdErr;

  logic [7:0] mem [256];
  logic [7:0] ramAddr;
  logic       ramTx;
  logic       forceNoTx;

  int checkCount = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_SIZE(8), .RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
    .busy(busy), .rd_err(rd_err)
  );

  ram_port_arbiter #(.ADDR_SIZE(8), .RR_EN(1'b0)) dutFp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fpReq0Ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(fpReq1Ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(fpRsp0Valid), .rsp0_rdata(fpRsp0Rdata),
    .rsp1_valid(fpRsp1Valid), .rsp1_rdata(fpRsp1Rdata),
    .ram_din(fpRamDin), .ram_rx_valid(fpRamRxValid),
    .ram_dout(8'h00), .ram_tx_valid(1'b0),
    .busy(fpBusy), .rd_err(fpRdErr)
  );

  // Behavioural RAM: read data and the sticky valid flag appear the cycle after the 11 strobe.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    ramAddr  = 8'h00;
    ramTx    = 1'b0;
    ram_dout = 8'h00;
  end

  always @(posedge clk) begin
    if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00, 2'b10: ramAddr <= ram_din[7:0];
        2'b01:        mem[ramAddr] <= ram_din[7:0];
        default: begin
          ram_dout <= mem[ramAddr];
          ramTx    <= 1'b1;
        end
      endcase
    end
  end

  assign ram_tx_valid = ramTx & ~forceNoTx;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int n, input logic valid, input logic we,
                               input logic [7:0] addr, input logic [7:0] wdata);
    if (n == 0) begin
      req0_valid = valid; req0_we = we; req0_addr = addr; req0_wdata = wdata;
    end else begin
      req1_valid = valid; req1_we = we; req1_addr = addr; req1_wdata = wdata;
    end
  endtask

  // Issues one transaction and waits a bounded number of cycles for accept and response.
  task automatic runTxn(input int n, input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                        output logic [7:0] rdata, output logic got);
    logic accepted;
    accepted = 1'b0;
    got      = 1'b0;
    rdata    = 8'h00;
    applyStimulus(n, 1'b1, we, addr, wdata);
    for (int i = 0; i < 6 && !accepted; i++) begin
      @(negedge clk);
      accepted = (n == 0) ? req0_ready : req1_ready;
      nextCycle();
    end
    applyStimulus(n, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if ((n == 0) ? rsp0_valid : rsp1_valid) begin
        got   = 1'b1;
        rdata = (n == 0) ? rsp0_rdata : rsp1_rdata;
      end
      nextCycle();
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic       got;
    logic [3:0] grantBits;
    int         nGrants, bothHigh, fpG0, fpG1, rsp0Seen;
    logic [5:0] rxPat;

    rst       = 1'b1;
    forceNoTx = 1'b0;
    applyStimulus(0, 1'b1, 1'b1, 8'h00, 8'h00);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset state, with a request pending that must not be granted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready0", req0_ready, 0);
    checkOutput("rst_rsp0v", rsp0_valid, 0);
    checkOutput("rst_rsp1v", rsp1_valid, 0);
    checkOutput("rst_rdata", {rsp0_rdata, rsp1_rdata}, 0);
    checkOutput("rst_din", ram_din, 0);
    checkOutput("rst_rx", ram_rx_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rderr", rd_err, 0);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b0;

    // Requester 0 writes 0xA5 to 0x12.
    applyStimulus(0, 1'b1, 1'b1, 8'h12, 8'hA5);
    @(negedge clk);
    checkOutput("wr_ready", {req1_ready, req0_ready}, 2'b01);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("wr_t1_din", ram_din, 10'h012);
    checkOutput("wr_t1_rx", {ram_rx_valid, busy}, 2'b11);
    nextCycle(); @(negedge clk);
    checkOutput("wr_t2_din", ram_din, 10'h1A5);
    checkOutput("wr_t2_rx", ram_rx_valid, 1);
    nextCycle(); @(negedge clk);
    checkOutput("wr_t3_rsp", {rsp0_valid, rsp0_rdata, ram_rx_valid}, {1'b1, 8'h00, 1'b0});
    nextCycle();

    // Requester 0 reads it back.
    applyStimulus(0, 1'b1, 1'b0, 8'h12, 8'h00);
    @(negedge clk);
    checkOutput("rd_ready", req0_ready, 1);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("rd_t1_din", ram_din, 10'h212);
    nextCycle(); @(negedge clk);
    checkOutput("rd_t2_din", {ram_rx_valid, ram_din}, {1'b1, 10'h300});
    nextCycle(); @(negedge clk);
    checkOutput("rd_t3_capt", {ram_rx_valid, ram_din, rsp0_valid}, 0);
    nextCycle(); @(negedge clk);
    checkOutput("rd_t4_rsp", {rsp0_valid, rsp0_rdata}, {1'b1, 8'hA5});
    checkOutput("rd_t4_err", rd_err, 0);
    nextCycle();

    // Contention after reset: round-robin alternates, fixed priority keeps requester 0.
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    applyStimulus(0, 1'b1, 1'b1, 8'h01, 8'h11);
    applyStimulus(1, 1'b1, 1'b1, 8'h02, 8'h22);
    grantBits = 4'b0000; nGrants = 0; bothHigh = 0; fpG0 = 0; fpG1 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) bothHigh++;
      if (req0_ready || req1_ready) begin
        grantBits = {grantBits[2:0], req1_ready};
        nGrants++;
      end
      if (fpReq0Ready) fpG0++;
      if (fpReq1Ready) fpG1++;
      nextCycle();
    end
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("rr_count", nGrants, 4);
    checkOutput("rr_order", grantBits, 4'b0101);
    checkOutput("rr_both_ready", bothHigh, 0);
    checkOutput("fp_grants0", fpG0, 4);
    checkOutput("fp_grants1", fpG1, 0);

    // Requester 0 writes 0x3C to 0xFF; requester 1 reads it, accepted alongside rsp0.
    applyStimulus(0, 1'b1, 1'b1, 8'hFF, 8'h3C);
    @(negedge clk);
    checkOutput("ff_wr_ready", req0_ready, 1);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
    nextCycle(); nextCycle();
    applyStimulus(1, 1'b1, 1'b0, 8'hFF, 8'h00);
    @(negedge clk);
    checkOutput("ff_rd_accept", {req1_ready, rsp0_valid}, 2'b11);
    rsp0Seen = 0;
    for (int i = 1; i <= 4; i++) begin
      nextCycle();
      if (i == 1) applyStimulus(1, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      if (rsp0_valid) rsp0Seen++;
    end
    checkOutput("ff_rsp1", {rsp1_valid, rsp1_rdata}, {1'b1, 8'h3C});
    checkOutput("ff_no_rsp0", rsp0Seen, 0);
    nextCycle();

    // Reset while in RCMD drops the transaction silently.
    applyStimulus(0, 1'b1, 1'b0, 8'h12, 8'h00);
    @(negedge clk);
    checkOutput("abort_ready", req0_ready, 1);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_rcmd", ram_din, 10'h300);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_outs", {busy, ram_rx_valid, ram_din, rsp0_valid, rsp1_valid, rd_err}, 0);
    checkOutput("abort_rdata", {rsp0_rdata, rsp1_rdata}, 0);
    nextCycle(); @(negedge clk);
    checkOutput("abort_no_rsp", {rsp0_valid, busy}, 0);
    nextCycle();
    runTxn(0, 1'b0, 8'h12, 8'h00, rd, got);
    checkOutput("abort_reread", {got, rd}, {1'b1, 8'hA5});

    // Back-to-back: read accepted in the same cycle as the write response.
    applyStimulus(0, 1'b1, 1'b1, 8'h40, 8'h5A);
    @(negedge clk);
    checkOutput("b2b_wr_ready", req0_ready, 1);
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 8'h40, 8'h00);
    rxPat = 6'b000000;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      rxPat = {rxPat[4:0], ram_rx_valid};
      if (k == 3) checkOutput("b2b_accept", {req0_ready, rsp0_valid}, 2'b11);
      nextCycle();
      if (k == 3) applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
    end
    @(negedge clk);
    checkOutput("b2b_rx_pattern", rxPat, 6'b110110);
    checkOutput("b2b_rsp", {rsp0_valid, rsp0_rdata}, {1'b1, 8'h5A});
    nextCycle();

    // rd_err sets when the RAM valid flag is low at capture and stays until reset.
    forceNoTx = 1'b1;
    runTxn(0, 1'b0, 8'h12, 8'h00, rd, got);
    checkOutput("err_got", got, 1);
    @(negedge clk);
    checkOutput("err_set", rd_err, 1);
    nextCycle();
    forceNoTx = 1'b0;
    runTxn(1, 1'b0, 8'h02, 8'h00, rd, got);
    checkOutput("err_rd_02", {got, rd}, {1'b1, 8'h22});
    @(negedge clk);
    checkOutput("err_sticky", rd_err, 1);
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("err_cleared", rd_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port 256x8 RAM between two independent requesters, for example the SPI slave and a local host.
- Accepts one read or write transaction per grant.
- Translates each transaction into the RAM's 10-bit command-word sequence on din/rx_valid, and returns a per-requester response.
- Sits directly in front of the RAM, which no longer connects to the SPI slave directly.

Parameters:
- ADDR_SIZE, 8, RAM address width. Must be ≤8; zero-extended into ram_din[7:0].
- RR_EN, 1, selects arbitration: 1 = round-robin, 0 = fixed priority with requester 0 winning.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- reqN_valid  in  1  (N=0,1) transaction request
- reqN_ready  out  1  high in the cycle requester N's request is accepted
- reqN_we  in  1  1 = write, 0 = read
- reqN_addr  in  ADDR_SIZE  target address
- reqN_wdata  in  8  write data
- rspN_valid  out  1  one-cycle pulse: transaction N complete
- rspN_rdata  out  8  read data, valid with rspN_valid; 0 for writes
- ram_din  out  10  command word {opcode[1:0], payload[7:0]}
- ram_rx_valid  out  1  command strobe to the RAM
- ram_dout  in  8  RAM read data
- ram_tx_valid  in  1  RAM read-valid flag; sticky once set
- busy  out  1  FSM not in IDLE
- rd_err  out  1  sticky: ram_tx_valid was low at a read capture

Behaviour:
- RAM opcodes:
  - 00 = latch address
  - 01 = write data
  - 10 = latch address (read path)
  - 11 = read; ram_dout is valid the cycle after the 11 strobe
- FSM states: IDLE, ADDR, WDATA, RCMD, CAPT.
- IDLE:
  - If any reqN_valid, the arbiter picks a winner and asserts reqN_ready combinationally in the same cycle.
  - we, addr and wdata are latched into internal registers; next state is ADDR.
  - reqN_ready is never high outside IDLE, and never high for both requesters in the same cycle.
- ADDR: ram_rx_valid=1, ram_din={we?00:10, addr}. Goes to WDATA if we, else RCMD.
- WDATA: ram_rx_valid=1, ram_din={01, wdata}. Goes to IDLE; registers rspN_valid=1 and rspN_rdata=0.
- RCMD: ram_rx_valid=1, ram_din={11, 8'h00}. Goes to CAPT.
- CAPT:
  - ram_rx_valid=0.
  - Registers rspN_rdata=ram_dout and rspN_valid=1; sets rd_err if ram_tx_valid==0.
  - Goes to IDLE.
- Outside ADDR, WDATA and RCMD: ram_rx_valid=0 and ram_din=0.
- Latency, with accept at cycle T:
  - Write: rsp_valid high in T+3.
  - Read: rsp_valid high in T+4.
  - A new accept may occur in the same cycle as rsp_valid, giving write throughput of 1 per 3 cycles and read throughput of 1 per 4 cycles.
- rspN_valid is high for exactly one cycle per accepted transaction. rspN_rdata holds its value until the next response to N.
- Arbitration:
  - last_grant register resets to 1, so requester 0 wins the first contention.
  - With RR_EN=1 and both requesters valid, the requester not equal to last_grant wins.
  - With a single valid requester, that requester wins.
  - last_grant updates on every accept.
- A requester must hold valid and its fields stable until ready. Fields are sampled only at accept.
- Reset, including mid-transaction:
  - FSM returns to IDLE; no response is produced for the in-flight transaction.
  - All outputs reset to 0: ready, rsp_valid, rsp_rdata, ram_din, ram_rx_valid, busy, rd_err.
  - last_grant resets to 1.
- Address wrap: addr above 255 cannot occur (ADDR_SIZE≤8). Address 255 and address 0 need no special handling.

Decomposition:
- Shared package:
  - Opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11.
  - FSM state encoding.
  - Command word width (10).
- Sub-module rr_arb2: two-input round-robin/fixed-priority grant with a last_grant register.
  - Inputs: clk, rst, req[1:0], en_update, rr_en.
  - Output: gnt[1:0], one-hot or zero.

Test Plan:
- Requester 0 writes addr 0x12 data 0xA5 -> ram_din=0x012 in T+1 and 0x1A5 in T+2, rx_valid high for those 2 cycles, rsp0_valid in T+3.
- Then requester 0 reads 0x12 -> ram_din=0x212 then 0x300, rsp0_valid in T+4 with rsp0_rdata=0xA5, rd_err=0.
- Both requesters valid continuously, writes to 0x01 and 0x02 -> grants alternate 0,1,0,1 with RR_EN=1. With RR_EN=0 only requester 0 is granted while it holds valid.
- Requester 1 reads 0xFF after requester 0 wrote 0x3C to 0xFF -> rsp1_rdata=0x3C. rsp0_valid stays 0 during requester 1's transaction.
- rst asserted in RCMD -> next cycle state is IDLE, all outputs 0, no rsp pulse. A subsequent read completes normally.
- Back-to-back: a read accepted in the same cycle as the previous write's rsp_valid -> no idle gap, ram_rx_valid pattern 1,1,0(IDLE),1,1,0.
